// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, ROM interface and IF/ID pipeline register.
// Handles sequential advance, stall, branch redirect (including a redirect latched
// during a stall), exception flush and misaligned-fetch marking.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_misalign,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc;
  logic        pend_valid;
  logic [31:0] pend_target;

  logic        rom_ce_next;
  logic [31:0] pc_next;
  logic        pend_valid_next;
  logic [31:0] pend_target_next;
  logic [31:0] id_pc_next;
  logic [31:0] id_inst_next;
  logic        id_valid_next;
  logic        id_misalign_next;
  logic [31:0] fetch_cnt_next;

  assign rom_addr = pc;

  // Next-state selection, highest priority first: ROM enable, flush, stall, branch,
  // pending redirect, then the sequential / misaligned fetch.
  always_comb begin
    rom_ce_next      = rom_ce;
    pc_next          = pc;
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;
    id_pc_next       = id_pc;
    id_inst_next     = id_inst;
    id_valid_next    = id_valid;
    id_misalign_next = id_misalign;
    fetch_cnt_next   = fetch_cnt;

    if (!rom_ce) begin
      // ROM data is not valid yet: enable it and present a bubble.
      rom_ce_next      = 1'b1;
      id_inst_next     = NOP_INST;
      id_valid_next    = 1'b0;
      id_misalign_next = 1'b0;
    end else if (flush) begin
      pc_next          = flush_pc;
      pend_valid_next  = 1'b0;
      id_inst_next     = NOP_INST;
      id_valid_next    = 1'b0;
      id_misalign_next = 1'b0;
    end else if (stall) begin
      // Hold everything; remember the latest branch so it applies once unstalled.
      if (branch_flag) begin
        pend_valid_next  = 1'b1;
        pend_target_next = branch_target;
      end
    end else if (branch_flag) begin
      // Kill the wrong-path instruction at the current pc.
      pc_next          = branch_target;
      pend_valid_next  = 1'b0;
      id_inst_next     = NOP_INST;
      id_valid_next    = 1'b0;
      id_misalign_next = 1'b0;
    end else if (pend_valid) begin
      pc_next          = pend_target;
      pend_valid_next  = 1'b0;
      id_inst_next     = NOP_INST;
      id_valid_next    = 1'b0;
      id_misalign_next = 1'b0;
    end else if (pc[1:0] != 2'b00) begin
      // Misaligned target: keep reporting it until a flush redirects the pc.
      id_pc_next       = pc;
      id_inst_next     = NOP_INST;
      id_valid_next    = 1'b1;
      id_misalign_next = 1'b1;
    end else begin
      id_pc_next       = pc;
      id_inst_next     = rom_inst;
      id_valid_next    = 1'b1;
      id_misalign_next = 1'b0;
      pc_next          = pc + 32'd4;
      fetch_cnt_next   = fetch_cnt + 32'd1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_ce      <= 1'b0;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
      id_pc       <= 32'h0;
      id_inst     <= NOP_INST;
      id_valid    <= 1'b0;
      id_misalign <= 1'b0;
      fetch_cnt   <= 32'h0;
    end else begin
      rom_ce      <= rom_ce_next;
      pc          <= pc_next;
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
      id_pc       <= id_pc_next;
      id_inst     <= id_inst_next;
      id_valid    <= id_valid_next;
      id_misalign <= id_misalign_next;
      fetch_cnt   <= fetch_cnt_next;
    end
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage (PC register plus IF/ID pipeline register) that drives the instruction ROM's chip enable and byte address.
- Captures the returned 32-bit RV32I instruction and passes it to the ID stage.
- Handles sequential PC advance, pipeline stall, branch redirect (including a redirect that arrives during a stall), exception flush, and misaligned-target detection.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven to ID when no valid instruction is present.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold request from downstream hazard logic.
- branch_flag  in  1  taken branch/jump resolved this cycle.
- branch_target  in  32  redirect address for branch_flag.
- flush  in  1  exception/trap flush.
- flush_pc  in  32  handler address for flush.
- rom_ce  out  1  ROM chip enable (registered).
- rom_addr  out  32  ROM byte address; always equals the internal pc register.
- rom_inst  in  32  ROM data; combinational from rom_addr and rom_ce within the same cycle.
- id_pc  out  32  PC of the instruction presented to ID.
- id_inst  out  32  instruction presented to ID.
- id_valid  out  1  id_inst is a real fetched instruction.
- id_misalign  out  1  fetch at pc[1:0]!=0; ID/EX raises an instruction-address-misaligned exception.
- fetch_cnt  out  32  count of valid aligned instructions delivered to ID.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - pc=RESET_PC, rom_ce=0
  - id_pc=0, id_inst=NOP_INST, id_valid=0, id_misalign=0
  - pend_valid=0, pend_target=0, fetch_cnt=0
- First edge with rst=0: rom_ce<=1. pc stays RESET_PC. IF/ID loads a bubble (id_inst=NOP_INST, id_valid=0, id_misalign=0).
- The same rules apply on any edge where rom_ce was 0: no advance, bubble loaded.
- Priority per edge with rom_ce=1: rst > flush > stall > branch_flag > pend_valid > sequential.
- flush=1:
  - pc<=flush_pc; pend_valid<=0; IF/ID<=bubble.
  - Overrides stall; the instruction in ID is discarded.
- stall=1, flush=0:
  - pc, id_pc, id_inst, id_valid, id_misalign and fetch_cnt hold.
  - If branch_flag=1: pend_valid<=1, pend_target<=branch_target. A newer branch_flag during the same stall overwrites pend_target.
- branch_flag=1, no stall/flush: pc<=branch_target; pend_valid<=0; IF/ID<=bubble (the wrong-path instruction at the current pc is killed).
- pend_valid=1, no stall/flush/branch_flag: pc<=pend_target; pend_valid<=0; IF/ID<=bubble.
  - The pending redirect therefore takes effect on the first unstalled edge.
  - If branch_flag coincides with that edge, branch_target wins and the pending target is dropped.
- Sequential (no stall, no redirect, pc[1:0]==0):
  - id_pc<=pc, id_inst<=rom_inst, id_valid<=1, id_misalign<=0.
  - pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
  - fetch_cnt<=fetch_cnt+1, wraps at 2^32.
- Misaligned (pc[1:0]!=0, no stall, no redirect):
  - id_pc<=pc, id_inst<=NOP_INST, id_valid<=1, id_misalign<=1.
  - pc holds; fetch_cnt holds.
  - This repeats until a flush redirects. The PC register never masks the low bits.
- Timing:
  - Latency from pc value to ID is one edge.
  - Redirect penalty is one bubble cycle.
  - rom_ce deasserts only in reset.
- rst asserted mid-operation (during a stall or with a pending redirect) discards all state and follows the reset values above.

Test Plan:
1. Reset then run: rst=1 for 2 cycles, rst=0, ROM holds 32'hFFF00093 @0 and 32'h00102023 @4.
   - First edge after release: rom_ce=1, id_valid=0.
   - Next edges: id_pc=0/id_inst=FFF00093, then id_pc=4/id_inst=00102023.
   - fetch_cnt=2 after both are delivered.
2. Stall: stall=1 for 3 cycles while id_pc=4.
   - id_pc/id_inst/pc/fetch_cnt stay constant.
   - After release, id_pc=8 on the next edge.
3. Branch: branch_flag=1, branch_target=32'h40 while id_pc=8.
   - Next edge: bubble (id_inst=00000013, id_valid=0).
   - The following edge: id_pc=32'h40.
4. Branch during stall: stall=1, branch_flag=1 target 32'h80, then branch_flag=1 target 32'h90 (still stalled), then stall=0.
   - First unstalled edge: bubble.
   - Then id_pc=32'h90; 32'h80 is never fetched.
5. Flush beats stall and branch:
   - flush=1 (flush_pc=32'h100), stall=1 and branch_flag=1 (target 32'h200) in the same cycle -> pc=32'h100, pending cleared, bubble, then id_pc=32'h100.
   - A separate flush while pend_valid=1 -> pc=flush_pc and the pending target is never fetched.
6. Misaligned and wrap:
   - branch_target=32'h42 -> id_misalign=1, id_pc=32'h42 repeated, fetch_cnt frozen, until flush to 32'h0.
   - Separately, flush_pc=32'hFFFF_FFFC -> id_pc=FFFFFFFC, then id_pc=0.
